// File: rtl/pwm_evt_irq.sv
// pwm_evt_irq: event capture and interrupt stage for the advanced PWM timer.
//
// Rising edges on the timer event lines are latched as pending flags. Each
// event has a saturating occurrence counter and a sticky overflow flag.
// A single registered level interrupt is driven from pending & mask.
//
// Ports:
//   clk        system clock (same domain as the timer event outputs)
//   reset      asynchronous, active-high reset
//   ev_i       timer event lines, level or pulse
//   reg_sel    register access strobe, one cycle per access
//   reg_wr     1 = write, 0 = read (qualified by reg_sel)
//   reg_addr   word index
//   reg_wdata  write data
//   reg_rdata  registered read data, holds until the next read
//   irq        registered level interrupt
//
// Register map (word index):
//   0 CTRL (en, R/W)   1 MASK (R/W)   2 PENDING (W1C)
//   3 COUNT (cnt[i] in byte i, cleared by read)   4 OVF (W1C)
//   5..7 read 0, writes ignored
module pwm_evt_irq #(
   parameter int EVCNT = 4,
   parameter int CW    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [EVCNT-1:0] ev_i,
   input  logic             reg_sel,
   input  logic             reg_wr,
   input  logic [2:0]       reg_addr,
   input  logic [31:0]      reg_wdata,
   output logic [31:0]      reg_rdata,
   output logic             irq
);

   localparam logic [2:0]    ADDR_CTRL    = 3'd0;
   localparam logic [2:0]    ADDR_MASK    = 3'd1;
   localparam logic [2:0]    ADDR_PENDING = 3'd2;
   localparam logic [2:0]    ADDR_COUNT   = 3'd3;
   localparam logic [2:0]    ADDR_OVF     = 3'd4;
   localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};

   logic [EVCNT-1:0] ev_q_r;
   logic [EVCNT-1:0] en_r;
   logic [EVCNT-1:0] mask_r;
   logic [EVCNT-1:0] pending_r;
   logic [EVCNT-1:0] ovf_r;
   logic [CW-1:0]    cnt_r     [EVCNT];

   logic [EVCNT-1:0] edge_s;
   logic [EVCNT-1:0] wdata_ev_s;
   logic             wr_s;
   logic             rd_s;
   logic             cnt_clr_s;
   logic [EVCNT-1:0] pending_clr_s;
   logic [EVCNT-1:0] ovf_clr_s;
   logic [EVCNT-1:0] pending_nxt_s;
   logic [EVCNT-1:0] ovf_nxt_s;
   logic [CW-1:0]    cnt_nxt_s [EVCNT];
   logic [31:0]      rdata_s;
   logic             unused_s;

   assign wr_s       = reg_sel & reg_wr;
   assign rd_s       = reg_sel & ~reg_wr;
   assign wdata_ev_s = reg_wdata[EVCNT-1:0];
   // Upper write-data bits carry no state.
   assign unused_s   = ^reg_wdata;

   // Edge is qualified by the enable so that enabling a high line yields no edge.
   assign edge_s = ev_i & ~ev_q_r & en_r;

   // Decode of clear strobes from register accesses.
   always_comb begin
      pending_clr_s = '0;
      ovf_clr_s     = '0;
      cnt_clr_s     = 1'b0;
      if (wr_s && (reg_addr == ADDR_PENDING)) begin
         pending_clr_s = wdata_ev_s;
      end else begin
         pending_clr_s = '0;
      end
      if (wr_s && (reg_addr == ADDR_OVF)) begin
         ovf_clr_s = wdata_ev_s;
      end else begin
         ovf_clr_s = '0;
      end
      if (rd_s && (reg_addr == ADDR_COUNT)) begin
         cnt_clr_s = 1'b1;
      end else begin
         cnt_clr_s = 1'b0;
      end
   end

   // Next-state of flags and counters; a set always beats a clear in the same cycle.
   always_comb begin
      pending_nxt_s = (pending_r & ~pending_clr_s) | edge_s;
      ovf_nxt_s     = ovf_r & ~ovf_clr_s;
      for (int i = 0; i < EVCNT; i++) begin
         cnt_nxt_s[i] = cnt_r[i];
         // Overflow is judged on the pre-clear value, so a read-clear at max still flags it.
         if (edge_s[i] && (cnt_r[i] == CNT_MAX)) begin
            ovf_nxt_s[i] = 1'b1;
         end else begin
            ovf_nxt_s[i] = ovf_nxt_s[i];
         end
         if (cnt_clr_s) begin
            cnt_nxt_s[i] = edge_s[i] ? CW'(1'b1) : '0;
         end else if (edge_s[i] && (cnt_r[i] != CNT_MAX)) begin
            cnt_nxt_s[i] = cnt_r[i] + CW'(1'b1);
         end else begin
            cnt_nxt_s[i] = cnt_r[i];
         end
      end
   end

   // Read data mux; unused bits and unmapped indices read 0.
   always_comb begin
      rdata_s = '0;
      case (reg_addr)
         ADDR_CTRL:    rdata_s[EVCNT-1:0] = en_r;
         ADDR_MASK:    rdata_s[EVCNT-1:0] = mask_r;
         ADDR_PENDING: rdata_s[EVCNT-1:0] = pending_r;
         ADDR_COUNT: begin
            for (int i = 0; i < EVCNT; i++) begin
               rdata_s[8*i +: 8] = 8'(cnt_r[i]);
            end
         end
         ADDR_OVF:     rdata_s[EVCNT-1:0] = ovf_r;
         default:      rdata_s = '0;
      endcase
   end

   // Event history, configuration, flags and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ev_q_r    <= '0;
         en_r      <= '0;
         mask_r    <= '0;
         pending_r <= '0;
         ovf_r     <= '0;
         for (int i = 0; i < EVCNT; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         ev_q_r    <= ev_i;
         pending_r <= pending_nxt_s;
         ovf_r     <= ovf_nxt_s;
         for (int i = 0; i < EVCNT; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
         if (wr_s && (reg_addr == ADDR_CTRL)) begin
            en_r <= wdata_ev_s;
         end else begin
            en_r <= en_r;
         end
         if (wr_s && (reg_addr == ADDR_MASK)) begin
            mask_r <= wdata_ev_s;
         end else begin
            mask_r <= mask_r;
         end
      end
   end

   // Registered read data and interrupt; irq follows the registered pending flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_rdata <= 32'd0;
         irq       <= 1'b0;
      end else begin
         irq <= |(pending_r & mask_r);
         if (rd_s) begin
            reg_rdata <= rdata_s;
         end else begin
            reg_rdata <= reg_rdata;
         end
      end
   end

endmodule

// File: tb/tb_pwm_evt_irq.sv
// Directed testbench for pwm_evt_irq (EVCNT=4, CW=8).
module tb_pwm_evt_irq;

   logic        clk;
   logic        reset;
   logic [3:0]  ev_i;
   logic        reg_sel;
   logic        reg_wr;
   logic [2:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        irq;

   int err_cnt;
   int chk_cnt;

   pwm_evt_irq #(.EVCNT(4), .CW(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .ev_i      (ev_i),
      .reg_sel   (reg_sel),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
      reg_sel = 1'b1; reg_wr = 1'b1; reg_addr = addr; reg_wdata = data;
      cyc();
      reg_sel = 1'b0; reg_wr = 1'b0;
   endtask

   task automatic reg_read(input logic [2:0] addr, output logic [31:0] data);
      reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = addr;
      cyc();
      reg_sel = 1'b0;
      data = reg_rdata;
   endtask

   task automatic pulse(input int ch);
      ev_i[ch] = 1'b1;
      cyc();
      ev_i[ch] = 1'b0;
      cyc();
   endtask

   logic [31:0] rd;

   initial begin
      err_cnt = 0; chk_cnt = 0;
      reset = 1'b1; ev_i = 4'h0; reg_sel = 1'b0; reg_wr = 1'b0;
      reg_addr = 3'd0; reg_wdata = 32'd0;
      cyc(); cyc();
      check_val("rst_rdata", reg_rdata, 32'h0);
      check_val("rst_irq", {31'd0, irq}, 32'h0);
      reset = 1'b0;
      cyc();

      // Basic edge -> pending -> irq, COUNT read-clear.
      reg_write(3'd0, 32'hF);
      reg_write(3'd1, 32'h1);
      reg_read(3'd0, rd);  check_val("ctrl_rb", rd, 32'hF);
      reg_read(3'd1, rd);  check_val("mask_rb", rd, 32'h1);
      ev_i[0] = 1'b1;
      cyc();
      ev_i[0] = 1'b0;
      check_val("irq_lat1", {31'd0, irq}, 32'h0);
      cyc();
      check_val("irq_lat2", {31'd0, irq}, 32'h1);
      reg_read(3'd2, rd);  check_val("pend_ch0", rd, 32'h1);
      reg_read(3'd3, rd);  check_val("count_1", rd, 32'h1);
      reg_read(3'd3, rd);  check_val("count_clr", rd, 32'h0);
      reg_write(3'd2, 32'h1);
      check_val("w1c_irq_m", {31'd0, irq}, 32'h1);
      cyc();
      check_val("w1c_irq_m1", {31'd0, irq}, 32'h0);

      // Held level counts once, then three separate pulses; masked out of irq.
      ev_i[2] = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      ev_i[2] = 1'b0;
      cyc();
      for (int i = 0; i < 3; i++) pulse(2);
      cyc();
      check_val("irq_masked", {31'd0, irq}, 32'h0);
      reg_read(3'd2, rd);  check_val("pend_ch2", rd, 32'h4);
      reg_read(3'd3, rd);  check_val("count_ch2", rd, 32'h0004_0000);
      reg_write(3'd2, 32'h4);

      // Saturation and sticky overflow on channel 1.
      for (int i = 0; i < 257; i++) pulse(1);
      reg_read(3'd3, rd);  check_val("count_sat", rd, 32'h0000_FF00);
      reg_read(3'd4, rd);  check_val("ovf_set", rd, 32'h2);
      reg_write(3'd4, 32'h2);
      reg_read(3'd4, rd);  check_val("ovf_clr", rd, 32'h0);
      reg_write(3'd2, 32'h2);

      // Set-vs-clear collision on PENDING.
      pulse(0);
      cyc();
      check_val("coll_irq_pre", {31'd0, irq}, 32'h1);
      reg_sel = 1'b1; reg_wr = 1'b1; reg_addr = 3'd2; reg_wdata = 32'h1;
      ev_i[0] = 1'b1;
      cyc();
      reg_sel = 1'b0; reg_wr = 1'b0; ev_i[0] = 1'b0;
      cyc();
      check_val("coll_irq", {31'd0, irq}, 32'h1);
      reg_read(3'd2, rd);  check_val("coll_pend", rd, 32'h1);

      // COUNT read-clear colliding with an edge: old value returned, cnt becomes 1.
      reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = 3'd3;
      ev_i[0] = 1'b1;
      cyc();
      reg_sel = 1'b0; ev_i[0] = 1'b0;
      check_val("coll_cnt_old", reg_rdata, 32'h2);
      reg_read(3'd3, rd);  check_val("coll_cnt_new", rd, 32'h1);
      reg_write(3'd2, 32'h1);

      // Enabling a channel whose line is already high yields no edge.
      reg_write(3'd0, 32'h7);
      ev_i[3] = 1'b1;
      cyc(); cyc();
      reg_write(3'd0, 32'hF);
      cyc(); cyc();
      reg_read(3'd3, rd);  check_val("en_high_noedge", rd, 32'h0);
      ev_i[3] = 1'b0;
      cyc();
      ev_i[3] = 1'b1;
      cyc();
      ev_i[3] = 1'b0;
      reg_read(3'd3, rd);  check_val("en_reedge", rd, 32'h0100_0000);

      // Unmapped index reads 0, writes ignored.
      reg_write(3'd6, 32'hFFFF_FFFF);
      reg_read(3'd6, rd);  check_val("idx6", rd, 32'h0);

      // Asynchronous reset mid-stream.
      reg_write(3'd1, 32'hF);
      ev_i = 4'hF;
      cyc();
      ev_i = 4'h0;
      cyc();
      check_val("pre_rst_irq", {31'd0, irq}, 32'h1);
      reg_read(3'd2, rd);  check_val("pre_rst_pend", rd, 32'hF);
      reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = 3'd2;
      #1;
      reset = 1'b1;
      #1;
      check_val("async_irq", {31'd0, irq}, 32'h0);
      check_val("async_rdata", reg_rdata, 32'h0);
      reg_sel = 1'b0;
      #2;
      reset = 1'b0;
      cyc();
      reg_read(3'd0, rd);  check_val("rst_ctrl", rd, 32'h0);
      reg_read(3'd1, rd);  check_val("rst_mask", rd, 32'h0);
      reg_read(3'd2, rd);  check_val("rst_pend", rd, 32'h0);
      reg_read(3'd3, rd);  check_val("rst_count", rd, 32'h0);
      reg_read(3'd4, rd);  check_val("rst_ovf", rd, 32'h0);
      reg_read(3'd6, rd);  check_val("rst_idx6", rd, 32'h0);
      check_val("rst_irq_after", {31'd0, irq}, 32'h0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/pwm_evt_irq.md
# pwm_evt_irq

Event capture and interrupt stage for the advanced PWM timer. It consumes the timer's per-channel event outputs, detects rising edges, and latches them as pending flags. It keeps a saturating occurrence counter per event and drives one level interrupt toward the system interrupt controller. Software reaches it through a simple word-indexed register port, decoded by the interface subsystem wrapper.

## Interface
- EVCNT, 4: number of timer event inputs (1..4)
- CW, 8: width of each per-event counter (1..8)

- clk  in  1  system clock; same domain as the timer's event outputs
- reset  in  1  asynchronous, active-high reset
- ev_i  in  EVCNT  timer event lines; synchronous to clk; level or pulse
- reg_sel  in  1  register access strobe, one cycle per access
- reg_wr  in  1  1 = write, 0 = read; qualified by reg_sel
- reg_addr  in  3  word index
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, registered
- irq  out  1  level interrupt, registered

## Operation
- Edge detect:
  - ev_q <= ev_i every cycle, regardless of enable.
  - edge[i] = ev_i[i] & ~ev_q[i] & en[i].
  - Enabling a channel while its line is high does not produce an edge.
- On edge[i]:
  - pending[i] <= 1.
  - cnt[i] <= cnt[i]+1, saturating at 2^CW-1.
  - An edge arriving while cnt[i] is already 2^CW-1 sets ovf[i] (sticky); cnt stays at max.
- irq <= |(pending & mask).
- Register map (word index):
  - 0 CTRL: [EVCNT-1:0] en. R/W.
  - 1 MASK: [EVCNT-1:0] irq enable. R/W.
  - 2 PENDING: [EVCNT-1:0]. Read returns flags; write-1-to-clear.
  - 3 COUNT: cnt[i] in byte i, zero-extended to 8 bits. A read clears all counters that are read.
  - 4 OVF: [EVCNT-1:0]. Read returns flags; write-1-to-clear.
  - 5–7: read 0; writes ignored.
- Unused upper bits read 0.
- Priority rules:
  - Set-vs-clear in the same cycle on PENDING or OVF: set wins; the flag stays 1.
  - COUNT read-clear in the same cycle as edge[i]: the read returns the pre-edge value, and cnt[i] becomes 1.
  - Read-clear at saturation plus edge in the same cycle: cnt[i] becomes 1, and ovf[i] is set.
- Clearing en[i] freezes cnt[i] and pending[i]; neither is cleared.
- Writing MASK affects irq from the next cycle.
- Reset clears everything immediately, including mid-access: ev_q, en, mask, pending, cnt, ovf, reg_rdata and irq all go to 0.

## Timing
- Cycle N: ev_i[i] rises (sampled at the clk edge ending N). After that edge, pending[i] = 1 and cnt is incremented. After edge N+1, irq = 1 if masked in. Edge-to-irq latency is 2 clocks.
- A pulse held high for k cycles counts once. Back-to-back separate pulses (high/low/high) count twice. Minimum detectable low gap is 1 cycle.
- Register access:
  - Single-cycle strobe; no wait states.
  - A write takes effect at the end of the reg_sel cycle.
  - A read takes its value at the end of the reg_sel cycle; reg_rdata is valid on the following cycle and holds until the next read.
  - Side effects (COUNT clear) occur at the end of the reg_sel cycle.
- W1C of PENDING at cycle M: irq deasserts after edge M+1, assuming no new edge.
- Back-to-back register accesses on consecutive cycles are legal.

## Test plan
- Reset, then CTRL=0xF, MASK=0x1. Pulse ev_i[0] for 1 cycle at N: pending=0x1 after N, irq=1 after N+1, COUNT reads 0x00000001 and then 0x00000000 on a second read.
- ev_i[2] held high for 10 cycles, then 3 separate 1-cycle pulses: cnt[2]=4. With MASK=0x1, irq stays 0 while pending=0x4.
- 257 pulses on ev_i[1] with CW=8: cnt[1]=0xFF and OVF=0x2. Write OVF=0x2: OVF=0.
- PENDING W1C=0x1 in the same cycle as a new ev_i[0] edge: pending[0] stays 1 and irq stays 1. The same collision on a COUNT read returns the old value and leaves cnt=1.
- With en[3]=0, raise ev_i[3] and hold it, then set en[3]=1: no edge, cnt[3]=0. Drop and re-raise ev_i[3]: cnt[3]=1.
- Assert reset mid-stream with pending=0xF and irq=1: all outputs 0 and all registers 0 in the same cycle; read of index 6 returns 0.
